// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_borrow_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [WIDTH-1:0] a_sh_next, b_sh_next;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             d_bit, br_next;
  logic             accept, last_bit;

  // Full-subtractor cell on the current LSBs.
  assign d_bit   = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
  assign br_next = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);

  // The minuend register doubles as the result register: each difference bit
  // enters the MSB slot vacated by the right shift, so after WIDTH shifts it
  // holds the complete difference.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_sh_next[gi] = a_sh_reg[gi+1];
      assign b_sh_next[gi] = b_sh_reg[gi+1];
    end
  endgenerate
  assign a_sh_next[WIDTH-1] = d_bit;
  assign b_sh_next[WIDTH-1] = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        last_bit = (cnt_reg == LAST);
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg <= '0;
      b_sh_reg <= '0;
      cnt_reg  <= '0;
      br_reg   <= 1'b0;
      D        <= '0;
      Bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf      <= 1'b0;
`endif
    end else if (accept) begin
      a_sh_reg <= A;
      b_sh_reg <= B;
      br_reg   <= Bin;
      cnt_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg <= a_sh_next;
      b_sh_reg <= b_sh_next;
      br_reg   <= br_next;
      cnt_reg  <= cnt_reg + CW'(1);
      if (last_bit) begin
        D    <= a_sh_next;
        Bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        // Borrow into the MSB differs from borrow out of it => signed overflow.
        ovf  <= br_reg ^ br_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor (WIDTH=4): vector table,
// handshake/reset sequences, adder cross-check and random ops vs arithmetic model.
module tb_serial_borrow_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_borrow_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap_errs = 0;

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      overlap_errs++;
      $display("FAIL busy_done_overlap at %0t: busy=%0b done=%0b", $time, busy, done);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait (bounded) for done; returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin, output int lat);
    @(posedge clk); #1;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;  // operands may change after capture
    wait_done(lat);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];
  int   lat;
  int   done_cnt;

  initial begin
    vecs[0] = '{4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[2] = '{4'b0011, 4'b0111, 1'b0, 4'b1100, 1'b1, 1'b0};
    vecs[3] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    vecs[4] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};
    vecs[5] = '{4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0};
    vecs[6] = '{4'b0111, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b0};
    vecs[7] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_D", D, 0);
    chk("reset_Bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
      $display("vec %0d: A=%b B=%b Bin=%b -> D=%b Bout=%b lat=%0d", i, vecs[i].a, vecs[i].b, vecs[i].bin, D, Bout, lat);
      chk("vec_latency", lat, 4);
      chk("vec_D", D, vecs[i].d);
      chk("vec_Bout", Bout, vecs[i].bout);
`ifdef SERIAL_SUB_OVF_EN
      chk("vec_ovf", ovf, vecs[i].ovf);
`endif
    end

    // start pulsed mid-RUN is ignored
    @(posedge clk); #1;
    A = 4'b1000; B = 4'b0011; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'b1111; B = 4'b0000; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    lat = lat + 2;
    $display("ignore_start: D=%b Bout=%b lat=%0d", D, Bout, lat);
    chk("ignore_latency", lat, 4);
    chk("ignore_D", D, 4'b0101);
    chk("ignore_Bout", Bout, 0);
    @(posedge clk); #1;
    chk("ignore_idle_busy", busy, 0);

    // Back-to-back with start held high
    @(posedge clk); #1;
    A = 4'b1111; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 4'b0111; B = 4'b0000; Bin = 1'b1;
    wait_done(lat);
    $display("b2b op1: D=%b Bout=%b lat=%0d", D, Bout, lat);
    chk("b2b1_latency", lat, 4);
    chk("b2b1_D", D, 4'b1110);
    chk("b2b1_Bout", Bout, 0);
    @(posedge clk); #1;
    chk("b2b_rerun_busy", busy, 1);
    chk("b2b_rerun_done", done, 0);
    wait_done(lat);
    lat = lat + 1;
    start = 1'b0;
    $display("b2b op2: D=%b Bout=%b period=%0d", D, Bout, lat);
    chk("b2b_period", lat, 5);
    chk("b2b2_D", D, 4'b0110);
    chk("b2b2_Bout", Bout, 0);

    // Reset asserted mid-RUN
    @(posedge clk); #1;
    A = 4'b0011; B = 4'b0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    $display("midrun_reset: busy=%b done=%b D=%b Bout=%b", busy, done, D, Bout);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_Bout", Bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle_busy", busy, 0);
    chk("rst_hold_D", D, 0);

    // Exhaustive cross-check against adder: D + B + Bin == A, carry == Bout
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          int sum;
          run_op(4'(a), 4'(b), 1'(c), lat);
          sum = int'(D) + b + c;
          chk("xchk_latency", lat, 4);
          chk("xchk_sum", 32'(sum % 16), 32'(a));
          chk("xchk_carry", 32'(sum / 16), 32'(Bout));
        end
      end
    end
    $display("xchk: 512 combinations done, errors so far %0d", errors);

    // Random ops against arithmetic model
    for (int i = 0; i < 100; i++) begin
      int a, b, c, sa, sb, sd, ed, eb, eo;
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      c = int'($urandom_range(1, 0));
      ed = (a - b - c + 32) % 16;
      eb = (a < b + c) ? 1 : 0;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      sd = sa - sb - c;
      eo = (sd < -8 || sd > 7) ? 1 : 0;
      run_op(4'(a), 4'(b), 1'(c), lat);
      $display("rand %0d: A=%0d B=%0d Bin=%0d -> D=%0d Bout=%0d (exp %0d %0d ovf %0d)", i, a, b, c, D, Bout, ed, eb, eo);
      chk("rand_latency", lat, 4);
      chk("rand_D", D, 32'(ed));
      chk("rand_Bout", Bout, 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
      chk("rand_ovf", ovf, 32'(eo));
`endif
    end

    @(posedge clk); #1;
    chk("busy_done_overlap", overlap_errs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial ripple-borrow subtractor: the inverse-direction counterpart of the 4-bit ripple-carry adder. It computes D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. A start/busy/done handshake runs it under a controller or self-checking bench. Its results are cross-checked against the combinational adder, since A = D + B + Bin with carry-out equal to Bout.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset; deassertion synchronous to clk
- start  in  1  request; sampled only in IDLE or DONE
- A  in  WIDTH  minuend, captured on the accepting edge
- B  in  WIDTH  subtrahend, captured on the accepting edge
- Bin  in  1  borrow-in, captured on the accepting edge
- busy  out  1  high while bits are being computed
- done  out  1  one-cycle pulse; D/Bout valid
- D  out  WIDTH  difference; holds last result until the next completion
- Bout  out  1  borrow-out of MSB (1 ⇔ A < B + Bin unsigned)
- ovf  out  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE; busy=0, done=0, D=0, Bout=0, ovf=0; bit counter, operand shift registers and borrow all 0.
- IDLE: when start=1, capture A, B and Bin (borrow reg ← Bin), set counter=0 and go to RUN.
- RUN: each cycle uses a=A_sh[0] and b=B_sh[0].
  - d = a^b^br
  - br ← (~a & b) | (~(a^b) & br)
  - d shifts into the MSB of the result shift reg; A_sh and B_sh shift right.
  - Counter increments.
  - The edge that processes bit WIDTH−1 loads D ← the completed result and Bout ← the final borrow, then moves to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1: re-captures and goes to RUN (back-to-back allowed).
  - Otherwise: go to IDLE.
- start in RUN is ignored. Operand inputs may change freely after capture.
- D, Bout and ovf change only on the completing edge or on reset. They are stable in all other cycles.

## Timing
- Accepting edge k: busy=1 from after edge k until after edge k+WIDTH.
- Bit i is computed on edge k+1+i. Results and done appear after edge k+WIDTH, which is WIDTH cycles of latency.
- busy and done are never both 1.
- Throughput is one operation per WIDTH+1 cycles when start is held high.
- Reset asserted mid-RUN aborts immediately: all outputs go to reset values, with no done pulse.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The ovf port exists.
  - On the completing edge, ovf ← (borrow into MSB) XOR Bout, i.e. two's-complement A−B−Bin is out of range.
  - ovf holds with D.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no overflow logic. All other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-RUN (A=0011, B=0001, start) → all outputs 0 immediately; no done pulse after release; state is IDLE.
- Basic: A=0011, B=0001, Bin=0 → done 4 cycles after accept; D=0010, Bout=0, ovf=0.
- Borrow chain: A=0000, B=0000, Bin=1 → D=1111, Bout=1, ovf=0.
- Underflow/overflow, each with Bin=0:
  - A=0011, B=0111 → D=1100, Bout=1, ovf=0.
  - A=1000, B=0001 → D=0111, Bout=0, ovf=1.
  - A=0111, B=1111 → D=1000, Bout=1, ovf=1.
- Handshake:
  - start pulsed again mid-RUN is ignored; the result is unchanged.
  - start held high gives back-to-back ops (A=1111, B=0001, Bin=0 → 1110; then A=0111, B=0000, Bin=1 → 0110) with done every 5 cycles.
  - busy and done are never both 1.
- Cross-check: exhaustive or random A, B, Bin against the combinational adder → Adder(D, B, Bin) = A with carry-out = Bout for all 512 combinations.
